// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and nibble decode for common-anode (active-low) displays.
// Segment order is {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex_en);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = hex_en ? SEG_A : SEG_BLANK;
            4'd11:   seg = hex_en ? SEG_B : SEG_BLANK;
            4'd12:   seg = hex_en ? SEG_C : SEG_BLANK;
            4'd13:   seg = hex_en ? SEG_D : SEG_BLANK;
            4'd14:   seg = hex_en ? SEG_E : SEG_BLANK;
            default: seg = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-low segment pattern.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int HEX_EN = 0
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_decode(nibble, HEX_EN != 0);
    end

endmodule

// File: rtl/seven_segment_scan_n.sv
// Time-multiplexed N-digit common-anode 7-segment driver with blink, decimal points,
// leading-zero blanking and per-slot dead time. Displays a snapshot captured on load_i.
module seven_segment_scan_n
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 32768,
    parameter int DEAD_CYCLES = 64,
    parameter int BLINK_DIV   = 16777216,
    parameter int HEX_EN      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic                  load_i,
    input  logic [N_DIGITS-1:0]   blink_mask_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic                  blank_lz_i,
    output logic [N_DIGITS-1:0]   anode_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  blink_phase_o
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int SEL_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0] sh_digits;
    logic [N_DIGITS-1:0]   sh_blink;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [BLINK_W-1:0]    blink_cnt;
    logic [SEL_W-1:0]      sel;

    logic [N_DIGITS-1:0]   lz_blank;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg;
    logic                  lit;

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        for (int unsigned k = 1; k < N_DIGITS; k++) begin
            lz_blank[k] = blank_lz_i && ((sh_digits >> (4 * k)) == '0);
        end
    end

    always_comb begin
        cur_nibble = sh_digits[4*int'(sel) +: 4];
        lit = (int'(scan_cnt) >= DEAD_CYCLES)
              && !(sh_blink[sel] && blink_phase_o)
              && !lz_blank[sel];
    end

    seg7_decoder #(.HEX_EN(HEX_EN)) u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits     <= '0;
            sh_blink      <= '0;
            sh_dp         <= '0;
            scan_cnt      <= '0;
            sel           <= '0;
            blink_cnt     <= '0;
            blink_phase_o <= 1'b0;
            anode_o       <= '1;
            seg_o         <= SEG_BLANK;
            dp_o          <= 1'b1;
        end else begin
            if (load_i) begin
                sh_digits <= digits_i;
                sh_blink  <= blink_mask_i;
                sh_dp     <= dp_i;
            end

            if (int'(scan_cnt) == SCAN_DIV - 1) begin
                scan_cnt <= '0;
                sel      <= (int'(sel) == N_DIGITS - 1) ? '0 : sel + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (int'(blink_cnt) == BLINK_DIV - 1) begin
                blink_cnt     <= '0;
                blink_phase_o <= ~blink_phase_o;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            anode_o <= '1;
            seg_o   <= SEG_BLANK;
            dp_o    <= 1'b1;
            if (lit) begin
                anode_o[sel] <= 1'b0;
                seg_o        <= dec_seg;
                dp_o         <= ~sh_dp[sel];
            end
        end
    end

endmodule
